// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder. Adds two WIDTH-bit operands LSB-first, BITS_PER_CYCLE
//   bits per clock, through a single carry-chained adder slice. It uses a
//   start/done handshake. {o_cout, o_sum} = i_a + i_b + i_cin.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     When defined, the block adds input i_sub and output o_ovf. With
//     i_sub=1 the block computes i_a - i_b, and i_cin is ignored. o_ovf
//     flags signed overflow.
//
// Parameters:
//   WIDTH           operand/sum width (>= 1)
//   BITS_PER_CYCLE  bits added per clock; must divide WIDTH
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_start  start request, sampled only while o_ready=1
//   i_a/i_b  operands, captured on an accepted start
//   i_cin    carry-in, captured on an accepted start
//   i_sub    (SUB_EN only) subtract select, captured with operands
//   o_ready  can accept i_start this cycle
//   o_busy   addition in progress
//   o_done   one-cycle pulse, result valid
//   o_sum    registered sum, held until next completion
//   o_cout   registered carry-out, held until next completion
//   o_ovf    (SUB_EN only) registered signed overflow
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             i_sub,
   output logic             o_ovf,
`endif
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int unsigned BPC   = BITS_PER_CYCLE;
   localparam int unsigned NSTEP = WIDTH / BPC;
   localparam int unsigned CW    = $clog2(NSTEP) + 1;

   generate
      if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_param
         $error("serial_adder: BITS_PER_CYCLE must be >= 1 and divide WIDTH >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_accept;
   logic             w_last;
   logic [BPC:0]     w_slice;
   logic [WIDTH-1:0] w_res_next;
   logic [WIDTH-1:0] w_b_cap;
   logic             w_cin_cap;

   assign w_accept = (r_state != StRun) && i_start;
   assign w_last   = (r_cnt == CW'(NSTEP - 1));

   // One adder slice; bit BPC is the carry into the next step.
   assign w_slice = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]} + {{BPC{1'b0}}, r_carry};

   // Slice sum enters at the top so that after NSTEP shifts bit 0 sits at the LSB.
   generate
      if (BPC == WIDTH) begin : g_res_full
         assign w_res_next = w_slice[BPC-1:0];
      end else begin : g_res_shift
         assign w_res_next = {w_slice[BPC-1:0], r_res[WIDTH-1:BPC]};
      end
   endgenerate

`ifdef SERIAL_ADDER_SUB_EN
   logic r_ovf;
   logic w_ovf;

   // After the final shift the slice holds the MSBs, so signed overflow
   // is visible here directly.
   assign w_ovf     = (r_a[BPC-1] == r_b[BPC-1]) && (w_slice[BPC-1] != r_a[BPC-1]);
   assign w_b_cap   = i_sub ? ~i_b : i_b;
   assign w_cin_cap = i_sub ? 1'b1 : i_cin;
   assign o_ovf     = r_ovf;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == StRun && w_last) begin
         r_ovf <= w_ovf;
      end
   end
`else
   assign w_b_cap   = i_b;
   assign w_cin_cap = i_cin;
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_next = StRun;
         StRun:   if (w_last) w_state_next = StDone;
         StDone:  w_state_next = i_start ? StRun : StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      o_ready = (r_state != StRun);
      o_busy  = (r_state == StRun);
      o_done  = (r_state == StDone);
   end

   assign o_sum  = r_sum;
   assign o_cout = r_cout;

   // Datapath
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a     <= i_a;
            r_b     <= w_b_cap;
            r_res   <= '0;
            r_carry <= w_cin_cap;
            r_cnt   <= '0;
         end else if (r_state == StRun) begin
            r_a     <= r_a >> BPC;
            r_b     <= r_b >> BPC;
            r_res   <= w_res_next;
            r_carry <= w_slice[BPC];
            r_cnt   <= r_cnt + 1'b1;
         end
         if (r_state == StRun && w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_slice[BPC];
         end
      end
   end

endmodule
